alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Round-robin arbiter that shares one ZipCPU ALU (ops 0-13, multi-cycle multiply) between NREQ requesters, e.g. a CPU pipeline slot and a packet checksum/DMA helper.
- Accepts valid/ready requests, issues one op per cycle into the ALU strobe interface, and honours ALU busy.
- Tracks the owner of the in-flight op and returns a registered result with flags to that requester only.

Parameters:
- NREQ, 2: number of requesters, 2..8.
- PTR_W, 3: round-robin pointer width; must satisfy 2**PTR_W >= NREQ.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  NREQ  per-requester request valid
- o_req_ready  out  NREQ  per-requester accept; one-hot or zero
- i_req_op  in  4*NREQ  ALU opcode, requester k at [4k+3:4k]
- i_req_a  in  32*NREQ  operand A, requester k at [32k+31:32k]
- i_req_b  in  32*NREQ  operand B, same packing as i_req_a
- o_alu_stb  out  1  ALU issue strobe
- o_alu_op  out  4  ALU opcode
- o_alu_a  out  32  ALU operand A
- o_alu_b  out  32  ALU operand B
- i_alu_valid  in  1  ALU result valid
- i_alu_c  in  32  ALU result
- i_alu_f  in  4  ALU flags {V,N,C,Z}
- i_alu_busy  in  1  ALU busy; multiply in progress
- o_res_valid  out  NREQ  one-hot result strobe to the owning requester
- o_res_data  out  32  registered result
- o_res_flags  out  4  registered flags
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (i_reset high at a clock edge):
  - o_res_valid=0, o_res_data=0, o_res_flags=0, o_err=0.
  - rr_ptr=0, inflight=0, owner=0.
  - o_alu_stb is forced low during the reset cycle.
- Grant (combinational):
  - Search i_req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - can_issue = !i_reset && !i_alu_busy && (any valid).
  - o_req_ready[g] = can_issue for winner g; all other bits are 0.
- Issue:
  - o_alu_stb = can_issue.
  - o_alu_op/a/b = winner's fields when can_issue, else 0.
  - Issue is a transfer: the same cycle request valid && ready.
  - On issue: owner<=g; inflight<=1; rr_ptr<=(g+1) mod NREQ, with wrap from NREQ-1 to 0.
  - rr_ptr holds when nothing is issued.
- Throughput:
  - Non-multiply ops: ALU valid follows stb by 1 cycle, so back-to-back issue every cycle is allowed.
  - owner is overwritten at the same edge as the returning result is captured. The capture uses the pre-edge owner, which is correct because results return in order.
- Multiply:
  - ALU raises busy the cycle after stb, which blocks further issue until valid.
  - owner and inflight hold while busy.
- Return (1-cycle registered):
  - If i_alu_valid && inflight: o_res_valid<=onehot(owner), o_res_data<=i_alu_c, o_res_flags<=i_alu_f.
  - Otherwise o_res_valid<=0; data and flags hold.
  - inflight<=0 on valid, unless a new issue occurs in the same cycle, in which case it stays 1.
- Errors:
  - i_alu_valid with inflight=0 is a protocol error: o_err<=1 (sticky until reset), and no o_res_valid pulse is generated.
  - Issue while i_alu_busy cannot occur by construction. The bench asserts this.
- Requester rules:
  - A requester may drop valid without a handshake; no state is lost.
  - Its fields must stay stable only in the cycle of transfer.
- Reset mid-multiply:
  - The pending result is abandoned; inflight clears and no o_res_valid pulse occurs for it.
  - A late i_alu_valid after reset sets o_err. The ALU shares i_reset, so in a correct system this does not occur.
- A single requester always valid gets every non-busy cycle.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- When defined, adds port o_grant_cnt (out, 16*NREQ):
  - Per-requester saturating issue counters, field k at [16k+15:16k].
  - Each increments on requester k's issue, saturates at 16'hFFFF, and clears to 0 on reset.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then req0 ADD a=5 b=7 -> o_alu_stb in cycle 0; o_res_valid=01 in cycle 2; o_res_data=12, flags C=0, Z=0.
- Both requesters valid continuously, NREQ=2, ops SUB → grants alternate 0,1,0,1 at one per cycle; each result routed to its owner in issue order; no lost or duplicated results.
- Req1 MPY a=3 b=4 with a 3-cycle ALU model, req0 valid throughout:
  - req0 ready=0 while i_alu_busy.
  - o_res_valid=10 with data 12.
  - req0 issues the cycle busy drops.
- NREQ=3, rr_ptr=2, valid=011 -> grant 0 (wrap), then rr_ptr=1.
- Spurious i_alu_valid with no issue -> o_err=1 and stays 1 until reset; o_res_valid stays 0.
- Reset asserted mid-multiply -> no result pulse; with ALU_SHARE_STATS_EN, counters read 0 after reset and saturate at 65535 after 70000 req0 issues.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one ZipCPU-style ALU between NREQ requesters
// Ports:
//   i_clk, i_reset                        clock, synchronous active-high reset
//   i_req_valid/o_req_ready               per-requester handshake (ready is one-hot or zero)
//   i_req_op/i_req_a/i_req_b              packed per-requester opcode and operands
//   o_alu_stb/o_alu_op/o_alu_a/o_alu_b    ALU issue strobe and operands
//   i_alu_valid/i_alu_c/i_alu_f/i_alu_busy ALU result, flags {V,N,C,Z} and multiply busy
//   o_res_valid/o_res_data/o_res_flags    registered result, strobed one-hot to its owner
//   o_err                                 sticky: ALU result with nothing in flight
// Optional: define ALU_SHARE_STATS_EN to add o_grant_cnt, per-requester saturating issue counters.
module alu_share_arb #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [4*NREQ-1:0]    i_req_op,
    input  logic [32*NREQ-1:0]   i_req_a,
    input  logic [32*NREQ-1:0]   i_req_b,
    output logic                 o_alu_stb,
    output logic [3:0]           o_alu_op,
    output logic [31:0]          o_alu_a,
    output logic [31:0]          o_alu_b,
    input  logic                 i_alu_valid,
    input  logic [31:0]          i_alu_c,
    input  logic [3:0]           i_alu_f,
    input  logic                 i_alu_busy,
    output logic [NREQ-1:0]      o_res_valid,
    output logic [31:0]          o_res_data,
    output logic [3:0]           o_res_flags,
`ifdef ALU_SHARE_STATS_EN
    output logic [16*NREQ-1:0]   o_grant_cnt,
`endif
    output logic                 o_err
);
    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);
    logic [PTR_W-1:0] rr_q, rr_d, owner_q, owner_d, win;
    logic             inflight_q, inflight_d, err_q, err_d, found, can_issue;
    logic [NREQ-1:0]  res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [3:0]       res_flags_q, res_flags_d;
    // Rotate valids so bit 0 is the requester at rr_q; first set bit is the winner's offset.
    always_comb begin
        logic [NREQ-1:0] rot;
        logic [PTR_W:0]  sum;
        rot = NREQ'({i_req_valid, i_req_valid} >> rr_q);
        found = 1'b0;
        sum = {1'b0, rr_q};
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum = {1'b0, rr_q} + (PTR_W+1)'(i);
            end
        end
        win = sum >= NREQ_W ? PTR_W'(sum - NREQ_W) : sum[PTR_W-1:0];
        can_issue = !i_reset && !i_alu_busy && found;
    end
    always_comb begin
        o_req_ready = '0;
        o_alu_op = '0;
        o_alu_a = '0;
        o_alu_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (can_issue && win == PTR_W'(i)) begin
                o_req_ready[i] = 1'b1;
                o_alu_op = i_req_op[4*i +: 4];
                o_alu_a = i_req_a[32*i +: 32];
                o_alu_b = i_req_b[32*i +: 32];
            end
        end
    end
    assign o_alu_stb = can_issue;
    // Results return in issue order, so the pre-edge owner always names the returning op.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            res_valid_d[i] = i_alu_valid && inflight_q && owner_q == PTR_W'(i);
        rr_d = can_issue ? (win == PTR_W'(NREQ-1) ? '0 : win + 1'b1) : rr_q;
        owner_d = can_issue ? win : owner_q;
        inflight_d = can_issue || (inflight_q && !i_alu_valid);
        res_data_d = i_alu_valid && inflight_q ? i_alu_c : res_data_q;
        res_flags_d = i_alu_valid && inflight_q ? i_alu_f : res_flags_q;
        err_d = err_q || (i_alu_valid && !inflight_q);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_q <= '0;
            owner_q <= '0;
            inflight_q <= 1'b0;
            res_valid_q <= '0;
            res_data_q <= '0;
            res_flags_q <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            owner_q <= owner_d;
            inflight_q <= inflight_d;
            res_valid_q <= res_valid_d;
            res_data_q <= res_data_d;
            res_flags_q <= res_flags_d;
            err_q <= err_d;
        end
    end
    assign o_res_valid = res_valid_q;
    assign o_res_data = res_data_q;
    assign o_res_flags = res_flags_q;
    assign o_err = err_q;
`ifdef ALU_SHARE_STATS_EN
    logic [16*NREQ-1:0] cnt_q;
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (i_reset)
                cnt_q[16*i +: 16] <= '0;
            else if (o_req_ready[i] && cnt_q[16*i +: 16] != 16'hFFFF)
                cnt_q[16*i +: 16] <= cnt_q[16*i +: 16] + 16'd1;
        end
    end
    assign o_grant_cnt = cnt_q;
`endif
endmodule
